// File: rtl/residue_reader_if.sv
// rtl/residue_reader_if.sv - request, memory-read and residue-stream signals of residue_reader
interface residue_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_mbnumber;
  logic        err;
  logic [12:0] mode_rd_addr;
  logic [2:0]  mode_rd_data;
  logic        res_rd_en;
  logic [15:0] res_rd_addr;
  logic [7:0]  res_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_mode;
  logic [7:0]  out_residue;
  logic [3:0]  out_index;
  logic        out_last;
  logic        out_allzero;

  modport slave (
    input  req_valid, req_mbnumber, mode_rd_data, res_rd_data, out_ready,
    output req_ready, err, mode_rd_addr, res_rd_en, res_rd_addr,
           out_valid, out_mode, out_residue, out_index, out_last, out_allzero
  );

  modport master (
    output req_valid, req_mbnumber, mode_rd_data, res_rd_data, out_ready,
    input  req_ready, err, mode_rd_addr, res_rd_en, res_rd_addr,
           out_valid, out_mode, out_residue, out_index, out_last, out_allzero
  );
endinterface

// File: rtl/residue_reader.sv
// rtl/residue_reader.sv - fetch one 4x4 block (mode + 16 residues) and stream it; RES_READER_ALLZERO_EN enables single-beat all-zero blocks
module residue_reader #(
  parameter int unsigned LENGTH  = 256,
  parameter int unsigned WIDTH   = 256,
  parameter int unsigned MBCOUNT = (LENGTH / 4) * (WIDTH / 4)
) (
  input logic             clk,
  input logic             reset,
  residue_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPT, STREAM} state_e;

  state_e      state_q, state_d;
  logic [12:0] mb_q, mb_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  mode_q, mode_d;
  logic        err_q, err_d;
  logic [15:0] res_addr_q, res_addr_d;
  logic [12:0] mode_addr_q, mode_addr_d;
  logic [7:0]  buf_q [16];
  logic [7:0]  buf_d [16];
`ifdef RES_READER_ALLZERO_EN
  logic [7:0]  or_q, or_d;
`endif

  function automatic logic [15:0] addr_of(input logic [12:0] mb, input logic [3:0] k);
    return 16'((32'(mb) / (WIDTH / 4) * 4 + 32'(k[3:2])) * WIDTH
               + 32'(mb) % (WIDTH / 4) * 4 + 32'(k[1:0]));
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mb_q        <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      mode_q      <= '0;
      err_q       <= 1'b0;
      res_addr_q  <= '0;
      mode_addr_q <= '0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
`ifdef RES_READER_ALLZERO_EN
      or_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mb_q        <= mb_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      res_addr_q  <= res_addr_d;
      mode_addr_q <= mode_addr_d;
      buf_q       <= buf_d;
`ifdef RES_READER_ALLZERO_EN
      or_q        <= or_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    mb_d        = mb_q;
    k_d         = k_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    err_d       = 1'b0;
    res_addr_d  = res_addr_q;
    mode_addr_d = mode_addr_q;
    buf_d       = buf_q;
`ifdef RES_READER_ALLZERO_EN
    or_d        = or_q;
`endif

    bus.req_ready    = 1'b0;
    bus.err          = err_q;
    bus.mode_rd_addr = mode_addr_q;
    bus.res_rd_en    = 1'b0;
    bus.res_rd_addr  = res_addr_q;
    bus.out_valid    = 1'b0;
    bus.out_mode     = mode_q;
    bus.out_residue  = buf_q[idx_q];
    bus.out_index    = idx_q;
    bus.out_last     = 1'b0;
    bus.out_allzero  = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (32'(bus.req_mbnumber) < MBCOUNT) begin
            mb_d        = bus.req_mbnumber;
            k_d         = '0;
            res_addr_d  = addr_of(bus.req_mbnumber, 4'd0);
            mode_addr_d = bus.req_mbnumber;
`ifdef RES_READER_ALLZERO_EN
            or_d        = '0;
`endif
            state_d     = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        bus.res_rd_en = 1'b1;
        // Read data lags the strobe by one cycle, so cycle k stores byte k-1.
        if (k_q != 4'd0) begin
          buf_d[k_q - 4'd1] = bus.res_rd_data;
`ifdef RES_READER_ALLZERO_EN
          or_d = or_q | bus.res_rd_data;
`endif
        end
        if (k_q == 4'd1) mode_d = bus.mode_rd_data;
        if (k_q == 4'd15) begin
          state_d = CAPT;
        end else begin
          k_d        = k_q + 4'd1;
          res_addr_d = addr_of(mb_q, k_q + 4'd1);
        end
      end
      CAPT: begin
        buf_d[15] = bus.res_rd_data;
`ifdef RES_READER_ALLZERO_EN
        or_d = or_q | bus.res_rd_data;
`endif
        idx_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (idx_q == 4'd15);
`ifdef RES_READER_ALLZERO_EN
        if (or_q == 8'd0) begin
          bus.out_allzero = 1'b1;
          bus.out_last    = 1'b1;
          bus.out_residue = '0;
          bus.out_index   = '0;
        end
`endif
        if (bus.out_ready) begin
          if (bus.out_last) state_d = IDLE;
          else              idx_d   = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_residue_reader.sv
// tb/tb_residue_reader.sv - self-checking bench for residue_reader with memory model and scoreboard
module tb_residue_reader;
  localparam int W   = 256;
  localparam int MBC = 4096;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  residue_reader_if bus();

  residue_reader #(.LENGTH(256), .WIDTH(256), .MBCOUNT(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] res_mem  [65536];
  logic [2:0] mode_mem [8192];

  always @(posedge clk) begin
    bus.mode_rd_data <= mode_mem[bus.mode_rd_addr];
    if (bus.res_rd_en) bus.res_rd_data <= res_mem[bus.res_rd_addr];
  end

  typedef struct {
    logic [7:0] r;
    logic [3:0] idx;
    logic       last;
    logic [2:0] mode;
    logic       az;
  } beat_t;

  beat_t       beat_q[$];
  logic [15:0] addr_q[$];
  logic [15:0] rd_log[$];
  logic [7:0]  acc_res[$];
  logic [3:0]  acc_idx[$];
  logic [2:0]  acc_mode[$];
  logic        acc_az[$];
  logic        acc_last[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_addr(input int mb, input int k);
    int row, col;
    row = (mb / (W / 4)) * 4 + k / 4;
    col = (mb % (W / 4)) * 4 + k % 4;
    return 16'(row * W + col);
  endfunction

  task automatic model_accept(input int mb);
    logic [7:0] orv;
    beat_t b;
    orv = '0;
    for (int k = 0; k < 16; k++) begin
      addr_q.push_back(model_addr(mb, k));
      orv |= res_mem[model_addr(mb, k)];
    end
`ifdef RES_READER_ALLZERO_EN
    if (orv == 8'd0) begin
      b.r = '0; b.idx = '0; b.last = 1'b1; b.mode = mode_mem[mb]; b.az = 1'b1;
      beat_q.push_back(b);
      return;
    end
`endif
    for (int k = 0; k < 16; k++) begin
      b.r = res_mem[model_addr(mb, k)]; b.idx = 4'(k); b.last = (k == 15);
      b.mode = mode_mem[mb]; b.az = 1'b0;
      beat_q.push_back(b);
    end
  endtask

  logic  exp_err = 1'b0;
  logic  stalled = 1'b0;
  beat_t held;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_res_rd_en", bus.res_rd_en, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_allzero", bus.out_allzero, 0);
      chk("rst_res_rd_addr", bus.res_rd_addr, 0);
      chk("rst_mode_rd_addr", bus.mode_rd_addr, 0);
      chk("rst_out_residue", bus.out_residue, 0);
      beat_q.delete();
      addr_q.delete();
      exp_err = 1'b0;
      stalled = 1'b0;
    end else begin
      chk("err", bus.err, exp_err);
      chk("req_ready", bus.req_ready, beat_q.size() == 0);
      if (bus.res_rd_en) begin
        chk("rd_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) chk("rd_addr", bus.res_rd_addr, addr_q.pop_front());
        rd_log.push_back(bus.res_rd_addr);
      end
      if (stalled) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_residue", bus.out_residue, held.r);
        chk("stall_index", bus.out_index, held.idx);
        chk("stall_last", bus.out_last, held.last);
        chk("stall_mode", bus.out_mode, held.mode);
        chk("stall_allzero", bus.out_allzero, held.az);
      end
      stalled = 1'b0;
      if (bus.out_valid) begin
        chk("beat_expected", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) begin
          chk("out_residue", bus.out_residue, beat_q[0].r);
          chk("out_index", bus.out_index, beat_q[0].idx);
          chk("out_last", bus.out_last, beat_q[0].last);
          chk("out_mode", bus.out_mode, beat_q[0].mode);
          chk("out_allzero", bus.out_allzero, beat_q[0].az);
          if (bus.out_ready) begin
            void'(beat_q.pop_front());
            acc_res.push_back(bus.out_residue);
            acc_idx.push_back(bus.out_index);
            acc_mode.push_back(bus.out_mode);
            acc_az.push_back(bus.out_allzero);
            acc_last.push_back(bus.out_last);
          end else begin
            stalled = 1'b1;
            held.r = bus.out_residue; held.idx = bus.out_index; held.last = bus.out_last;
            held.mode = bus.out_mode; held.az = bus.out_allzero;
          end
        end
      end
      exp_err = bus.req_valid && bus.req_ready && (32'(bus.req_mbnumber) >= MBC);
      if (bus.req_valid && bus.req_ready && (32'(bus.req_mbnumber) < MBC))
        model_accept(int'(bus.req_mbnumber));
    end
  end

  task automatic clear_logs();
    rd_log.delete(); acc_res.delete(); acc_idx.delete();
    acc_mode.delete(); acc_az.delete(); acc_last.delete();
  endtask

  task automatic do_req(input int mb);
    bus.req_valid    = 1'b1;
    bus.req_mbnumber = 13'(mb);
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    int n = 0;
    while ((bus.out_valid || !bus.req_ready) && n < 300) begin
      if (toggle) bus.out_ready = (n % 3 == 0);
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", n < 300, 1);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int n;
    for (int a = 0; a < 65536; a++) res_mem[a] = 8'((a * 7) % 255 + 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        res_mem[i * 256 + j]      = 8'(i * 4 + j + 1);
        res_mem[i * 256 + 40 + j] = 8'd0;
      end
    for (int m = 0; m < 8192; m++) mode_mem[m] = 3'(m % 8);
    mode_mem[0] = 3'd5;

    bus.req_valid = 1'b0; bus.req_mbnumber = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Block 0: address order, latency, beats 1..16, mode 5
    clear_logs();
    do_req(0);
    n = 0;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("first_beat_latency", n, 17);
    wait_done(1'b0);
    chk("b0_beats", acc_res.size(), 16);
    chk("b0_reads", rd_log.size(), 16);
    if (acc_res.size() == 16 && rd_log.size() == 16) begin
      for (int k = 0; k < 16; k++) chk("b0_residue", acc_res[k], k + 1);
      chk("b0_addr0", rd_log[0], 0);
      chk("b0_addr4", rd_log[4], 256);
      chk("b0_addr15", rd_log[15], 771);
      chk("b0_mode", acc_mode[0], 5);
      chk("b0_last15", acc_last[15], 1);
      chk("b0_last14", acc_last[14], 0);
    end

    // Block 65: brow=1, bcol=1
    clear_logs();
    do_req(65);
    wait_done(1'b0);
    chk("b65_reads", rd_log.size(), 16);
    if (rd_log.size() == 16) begin
      chk("b65_addr_first", rd_log[0], 1028);
      chk("b65_addr_last", rd_log[15], 1799);
    end

    // Out-of-range request
    clear_logs();
    do_req(4096);
    chk("rej_err_pulse", bus.err, 1);
    chk("rej_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    chk("rej_err_drop", bus.err, 0);
    repeat (4) @(posedge clk); #1;
    chk("rej_no_reads", rd_log.size(), 0);

    // Backpressure pattern 1,0,0
    clear_logs();
    do_req(7);
    wait_done(1'b1);
    chk("bp_beats", acc_idx.size(), 16);
    if (acc_idx.size() == 16)
      for (int k = 0; k < 16; k++) chk("bp_index", acc_idx[k], k);

    // Reset during STREAM at index 7
    do_req(2);
    n = 0;
    while (!(bus.out_valid && bus.out_index == 4'd7) && n < 60) begin @(posedge clk); #1; n++; end
    chk("reach_idx7", n < 60, 1);
    #1 reset = 1'b0;
    #1 chk("rst_async_valid", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    do_req(3);
    wait_done(1'b0);
    chk("post_rst_beats", acc_idx.size(), 16);
    if (acc_idx.size() != 0) chk("post_rst_first_idx", acc_idx[0], 0);

    // All-zero block
    clear_logs();
    do_req(10);
    wait_done(1'b0);
`ifdef RES_READER_ALLZERO_EN
    chk("az_beats", acc_az.size(), 1);
    if (acc_az.size() == 1) begin
      chk("az_flag", acc_az[0], 1);
      chk("az_last", acc_last[0], 1);
    end
    clear_logs();
    do_req(11);
    wait_done(1'b0);
    chk("nz_beats", acc_az.size(), 16);
    if (acc_az.size() != 0) chk("nz_flag", acc_az[0], 0);
`else
    chk("zero_blk_beats", acc_az.size(), 16);
    if (acc_az.size() != 0) chk("zero_blk_flag", acc_az[0], 0);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/residue_reader.md
# residue_reader

Reads back one 4x4 intra-prediction result from the residue/mode store: the 3-bit winning mode and the 16 residue bytes for a requested block number. Sits downstream of the intra-prediction saver, between the frame-sized residue/mode memories and the reconstruction/entropy stage. Fetches into a local buffer, then streams one residue per beat over a valid/ready interface.

## Interface
- LENGTH, 256, frame height in pixels
- WIDTH, 256, frame width in pixels; multiple of 4
- MBCOUNT, 4096, number of valid block numbers, (LENGTH/4)*(WIDTH/4)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  block request present
- req_ready  out  1  high only in IDLE
- req_mbnumber  in  13  requested block number
- err  out  1  one-cycle pulse: request rejected, out of range
- mode_rd_addr  out  13  mode memory address
- mode_rd_data  in  3  mode memory data, 1-cycle synchronous read
- res_rd_en  out  1  residue memory read strobe
- res_rd_addr  out  16  residue memory byte address
- res_rd_data  in  8  residue memory data, valid the cycle after res_rd_en
- out_valid  out  1  residue beat valid
- out_ready  in  1  consumer accepts beat
- out_mode  out  3  mode of current block, stable for the whole stream
- out_residue  out  8  residue byte
- out_index  out  4  raster position i*4+j within the 4x4 block
- out_last  out  1  final beat of block
- out_allzero  out  1  block has all-zero residues (see Configuration)

## Operation
- States: IDLE, FETCH, CAPT, STREAM.
- IDLE: req_ready=1. On req_valid with req_mbnumber < MBCOUNT, latch mbnumber and go to FETCH.
- Out-of-range request (>= MBCOUNT) is consumed: err pulses for the next cycle, no memory reads, stay IDLE.
- Block placement: brow = mb / (WIDTH/4), bcol = mb % (WIDTH/4).
- Byte k (i=k>>2, j=k&3) is at address (brow*4+i)*WIDTH + bcol*4 + j. Truncate the address to 16 bits.
- FETCH: 16 cycles, k=0..15. Drive res_rd_en=1 and res_rd_addr(k). On k=0, also drive mode_rd_addr=mb.
- Data returned for k is written to buf[k] on the following edge. Mode is captured on the edge after k=0. Then go to CAPT.
- CAPT: 1 cycle. Capture buf[15], then go to STREAM.
- STREAM: present buf[idx] with out_index=idx and out_last=(idx==15).
  - Advance idx on out_valid && out_ready.
  - When the idx-15 beat is accepted, go to IDLE.
- Backpressure: all out_* are held stable while out_valid && !out_ready.
- res_rd_en=0 outside FETCH. Address outputs hold their last value.
- Reset at any time: return to IDLE immediately. The in-flight block is discarded and no partial stream resumes.

## Timing
- Reset values: req_ready=1, err=0, res_rd_en=0, out_valid=0, out_last=0, out_allzero=0; all address and data outputs 0.
- Request accepted at edge E0.
  - FETCH runs E0..E16.
  - CAPT runs E16..E17.
  - out_valid rises after E17, giving 17 cycles to the first beat.
- With out_ready held high: 16 beats on consecutive cycles. req_ready is high again after the edge that accepts the last beat.
- Minimum block period is 34 cycles; there is no overlap between blocks.
- err asserts for exactly the cycle after the rejecting edge. req_ready stays high, so back-to-back requests are allowed.

## Configuration
- RES_READER_ALLZERO_EN defined:
  - During FETCH, accumulate the OR of all 16 returned bytes.
  - If the OR is zero, STREAM emits a single beat: out_residue=0, out_index=0, out_last=1, out_allzero=1. Then go to IDLE.
  - Otherwise emit 16 beats as normal with out_allzero=0.
- Undefined: out_allzero is tied 0 and every block always streams 16 beats.

## Test plan
- Reset, then request mb=0 with memory holding bytes 1..16 at addresses {0..3, 256..259, 512..515, 768..771} and mode 5.
  -> reads issued in that address order; out_valid after 17 cycles; beats 1..16 with out_mode=5; out_last on index 15.
- Request mb=65 (brow=1, bcol=1).
  -> first res_rd_addr=1028, last=1799.
- Request mb=4096.
  -> err pulse of 1 cycle; res_rd_en never asserts; req_ready stays 1.
- Stream with out_ready toggling 1,0,0,1...
  -> no beat lost or duplicated; outputs stable during stalls; all indices 0..15 delivered in order.
- Assert reset during STREAM at index 7.
  -> out_valid=0 immediately; after release, a new request mb=3 streams from index 0.
- With RES_READER_ALLZERO_EN defined and an all-zero block.
  -> single beat with out_last=1, out_allzero=1; a nonzero block gives 16 beats with out_allzero=0.
